// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: opcodes, FSM states, address width.
package pipe_hazard_ctrl_pkg;

   localparam int unsigned REG_ADDR_WIDTH_DEF = 5;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      StRun      = 2'd0,
      StDmemWait = 2'd1,
      StImemWait = 2'd2,
      StDiscard  = 2'd3
   } hz_state_e;

endpackage

// File: rtl/pipe_hazard_reguse.sv
// Source-register usage decode for the IF/ID instruction and load-use hazard compare.
module pipe_hazard_reguse
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned RegAddrWidth = REG_ADDR_WIDTH_DEF
) (
   input  logic [6:0]              opcode_i,
   input  logic [RegAddrWidth-1:0] rs1_i,
   input  logic [RegAddrWidth-1:0] rs2_i,
   input  logic                    mem_read_i,
   input  logic [RegAddrWidth-1:0] rd_i,
   output logic                    load_use_o
);

   logic use_rs1;
   logic use_rs2;

   always_comb begin
      use_rs1 = !(opcode_i == OP_LUI || opcode_i == OP_AUIPC || opcode_i == OP_JAL);
      use_rs2 = (opcode_i == OP_RTYPE || opcode_i == OP_STORE || opcode_i == OP_BRANCH);
   end

   // x0 is hardwired zero, so a load targeting it can never create a dependency.
   assign load_use_o = mem_read_i && (rd_i != '0) &&
                       ((use_rs1 && (rs1_i == rd_i)) || (use_rs2 && (rs2_i == rd_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline.
// Optional performance counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [6:0]                IF_ID_inst_opcode,
   input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
   input  logic                      ID_EX_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
   input  logic                      EX_branch_taken,
   input  logic                      EX_MEM_mem_access,
   input  logic                      dmem_ready,
   input  logic                      imem_ready,
   output logic                      pc_write,
   output logic                      IF_ID_write,
   output logic                      IF_flush,
   output logic                      ID_EX_flush,
   output logic                      pipe_freeze
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0]      perf_stall_cnt,
   output logic [CNT_WIDTH-1:0]      perf_flush_cnt,
   output logic [CNT_WIDTH-1:0]      perf_loaduse_cnt
`endif
);

   hz_state_e state_q, state_d;
   logic      load_use;
   logic      dmem_busy;
   logic      pc_write_c, if_id_write_c, if_flush_c, id_ex_flush_c, freeze_c;
   logic      flush_fire, loaduse_fire;

   pipe_hazard_reguse #(
      .RegAddrWidth (REG_ADDR_WIDTH)
   ) u_reguse (
      .opcode_i   (IF_ID_inst_opcode),
      .rs1_i      (IF_ID_rs1),
      .rs2_i      (IF_ID_rs2),
      .mem_read_i (ID_EX_mem_read),
      .rd_i       (ID_EX_rd),
      .load_use_o (load_use)
   );

   assign dmem_busy = EX_MEM_mem_access && !dmem_ready;

   always_comb begin
      pc_write_c    = 1'b1;
      if_id_write_c = 1'b1;
      if_flush_c    = 1'b0;
      id_ex_flush_c = 1'b0;
      freeze_c      = 1'b0;
      flush_fire    = 1'b0;
      loaduse_fire  = 1'b0;
      state_d       = state_q;
      if (dmem_busy) begin
         // A branch in EX is frozen in place and redirects once the freeze lifts.
         pc_write_c    = 1'b0;
         if_id_write_c = 1'b0;
         freeze_c      = 1'b1;
         state_d       = StDmemWait;
      end else if (state_q == StDiscard) begin
         pc_write_c    = 1'b0;
         if_id_write_c = 1'b0;
         if (imem_ready) begin
            if_flush_c = 1'b1;
            state_d    = StRun;
         end
         if (EX_branch_taken) begin
            pc_write_c = 1'b1;
            state_d    = StDiscard;
         end
      end else if (EX_branch_taken) begin
         pc_write_c    = 1'b1;
         if_flush_c    = 1'b1;
         id_ex_flush_c = 1'b1;
         flush_fire    = 1'b1;
         state_d       = imem_ready ? StRun : StDiscard;
      end else if (load_use) begin
         pc_write_c    = 1'b0;
         if_id_write_c = 1'b0;
         id_ex_flush_c = 1'b1;
         loaduse_fire  = 1'b1;
      end else if (!imem_ready) begin
         pc_write_c = 1'b0;
         if_flush_c = 1'b1;
         state_d    = StImemWait;
      end else begin
         state_d = StRun;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // Force default controls while in reset regardless of input activity.
   assign pc_write    = !reset_n || pc_write_c;
   assign IF_ID_write = !reset_n || if_id_write_c;
   assign IF_flush    = reset_n && if_flush_c;
   assign ID_EX_flush = reset_n && id_ex_flush_c;
   assign pipe_freeze = reset_n && freeze_c;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q, loaduse_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
         loaduse_cnt_q <= '0;
      end else begin
         if (!pc_write_c && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
         end
         if (flush_fire && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
         end
         if (loaduse_fire && (loaduse_cnt_q != '1)) begin
            loaduse_cnt_q <= loaduse_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   assign perf_stall_cnt   = stall_cnt_q;
   assign perf_flush_cnt   = flush_cnt_q;
   assign perf_loaduse_cnt = loaduse_cnt_q;
`else
   logic unused_perf;
   assign unused_perf = flush_fire ^ loaduse_fire;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues expected controls, monitor checks them.
module tb_pipe_hazard_ctrl;

   localparam logic [6:0] OpR     = 7'b0110011;
   localparam logic [6:0] OpLui   = 7'b0110111;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpAddi  = 7'b0010011;
   localparam int unsigned CntW   = 32;

   logic       clk;
   logic       reset_n;
   logic [6:0] opcode;
   logic [4:0] rs1, rs2, rd;
   logic       mem_read, br_taken, mem_access, dmem_ready, imem_ready;
   logic       pc_write, if_id_write, if_flush, id_ex_flush, pipe_freeze;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [CntW-1:0] perf_stall_cnt, perf_flush_cnt, perf_loaduse_cnt;
`endif

   typedef struct {
      logic [4:0] exp;
      string      name;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   pipe_hazard_ctrl #(
      .REG_ADDR_WIDTH (5),
      .CNT_WIDTH      (CntW)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .IF_ID_inst_opcode (opcode),
      .IF_ID_rs1         (rs1),
      .IF_ID_rs2         (rs2),
      .ID_EX_mem_read    (mem_read),
      .ID_EX_rd          (rd),
      .EX_branch_taken   (br_taken),
      .EX_MEM_mem_access (mem_access),
      .dmem_ready        (dmem_ready),
      .imem_ready        (imem_ready),
      .pc_write          (pc_write),
      .IF_ID_write       (if_id_write),
      .IF_flush          (if_flush),
      .ID_EX_flush       (id_ex_flush),
      .pipe_freeze       (pipe_freeze)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      ,
      .perf_stall_cnt    (perf_stall_cnt),
      .perf_flush_cnt    (perf_flush_cnt),
      .perf_loaduse_cnt  (perf_loaduse_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   // Expected vector order: {pc_write, IF_ID_write, IF_flush, ID_EX_flush, pipe_freeze}
   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         n_tests++;
         if ({pc_write, if_id_write, if_flush, id_ex_flush, pipe_freeze} !== mon_e.exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", mon_e.name,
                     {pc_write, if_id_write, if_flush, id_ex_flush, pipe_freeze}, mon_e.exp);
         end
      end
   end

   task automatic step(input logic rn, input logic [6:0] opc, input logic [4:0] r1,
                       input logic [4:0] r2, input logic mr, input logic [4:0] d,
                       input logic bt, input logic ma, input logic dr, input logic ir,
                       input logic [4:0] exp, input string name);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n    = rn;
      opcode     = opc;
      rs1        = r1;
      rs2        = r2;
      mem_read   = mr;
      rd         = d;
      br_taken   = bt;
      mem_access = ma;
      dmem_ready = dr;
      imem_ready = ir;
      e.exp      = exp;
      e.name     = name;
      q.push_back(e);
   endtask

   task automatic idle(input string name);
      step(1, OpR, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11000, name);
   endtask

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   task automatic check_cnt(input string name, input logic [CntW-1:0] got,
                            input logic [CntW-1:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, got, req);
      end
   endtask
`endif

   initial begin
      reset_n = 1'b0;
      opcode = OpR; rs1 = 0; rs2 = 0; rd = 0;
      mem_read = 0; br_taken = 0; mem_access = 0; dmem_ready = 1; imem_ready = 1;

      // Hostile inputs under reset must still give defaults.
      step(0, OpR, 5, 0, 1, 5, 1, 1, 0, 0, 5'b11000, "reset_out");
      idle("idle_after_reset");

      step(1, OpR, 5, 0, 1, 5, 0, 0, 1, 1, 5'b00010, "loaduse_rs1");
      step(1, OpR, 5, 0, 0, 5, 0, 0, 1, 1, 5'b11000, "loaduse_release");
      step(1, OpR, 0, 0, 1, 0, 0, 0, 1, 1, 5'b11000, "rd_x0_no_stall");
      step(1, OpLui, 5, 0, 1, 5, 0, 0, 1, 1, 5'b11000, "lui_no_rs1");
      step(1, OpStore, 1, 7, 1, 7, 0, 0, 1, 1, 5'b00010, "loaduse_store_rs2");
      step(1, OpAddi, 1, 7, 1, 7, 0, 0, 1, 1, 5'b11000, "itype_no_rs2");

      step(1, OpR, 0, 0, 0, 0, 1, 0, 1, 1, 5'b11110, "branch_flush");
      idle("branch_after");
      step(1, OpR, 5, 0, 1, 5, 1, 0, 1, 1, 5'b11110, "branch_beats_loaduse");
      idle("branch_lu_after");

      for (int i = 0; i < 3; i++) step(1, OpR, 0, 0, 0, 0, 0, 0, 1, 0, 5'b01100, "imem_wait");
      idle("imem_ready");

      step(1, OpR, 0, 0, 0, 0, 1, 0, 1, 0, 5'b11110, "branch_in_fetch");
      for (int i = 0; i < 2; i++) step(1, OpR, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, "discard_wait");
      step(1, OpR, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00100, "discard_drop");
      idle("discard_after");

      for (int i = 0; i < 4; i++) step(1, OpR, 0, 0, 0, 0, 1, 1, 0, 1, 5'b00001, "dmem_freeze");
      step(1, OpR, 0, 0, 0, 0, 1, 0, 1, 1, 5'b11110, "freeze_exit_branch");
      idle("freeze_after");

      step(1, OpR, 0, 0, 0, 0, 0, 1, 0, 1, 5'b00001, "freeze_pre_reset");
      step(0, OpR, 0, 0, 0, 0, 0, 1, 0, 1, 5'b11000, "reset_mid_freeze");
      idle("reset_release");

      step(1, OpR, 0, 0, 0, 0, 1, 0, 1, 0, 5'b11110, "branch_in_fetch2");
      step(1, OpR, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, "discard_wait2");
      step(0, OpR, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11000, "reset_in_discard");
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      #1;
      check_cnt("perf_stall_reset", perf_stall_cnt, 0);
      check_cnt("perf_flush_reset", perf_flush_cnt, 0);
      check_cnt("perf_loaduse_reset", perf_loaduse_cnt, 0);
`endif
      // A lingering discard would show IF_flush with pc_write low here.
      idle("discard_cleared");

      step(1, OpR, 5, 0, 1, 5, 0, 0, 1, 1, 5'b00010, "tally_loaduse");
      idle("tally_idle1");
      step(1, OpR, 0, 0, 0, 0, 1, 0, 1, 1, 5'b11110, "tally_branch");
      idle("tally_idle2");
      for (int i = 0; i < 2; i++) step(1, OpR, 0, 0, 0, 0, 0, 0, 1, 0, 5'b01100, "tally_imem");
      idle("tally_ready");

      @(posedge clk);
      #1;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      check_cnt("perf_stall", perf_stall_cnt, 3);
      check_cnt("perf_flush", perf_flush_cnt, 1);
      check_cnt("perf_loaduse", perf_loaduse_cnt, 1);
`endif
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage RISC-V pipeline. Drives the PC write enable, the IF/ID write and flush controls, the ID/EX bubble insert and a whole-pipe freeze.
- Detects load-use hazards from IF/ID register fields and flushes on taken branches or jumps resolved in EX.
- Tracks multi-cycle instruction-memory and data-memory waits, including discarding a stale fetch after a redirect.

Parameters:
- REG_ADDR_WIDTH, 5, register address width.
- CNT_WIDTH, 32, width of each performance counter (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- IF_ID_inst_opcode  in  7  opcode of the instruction held in IF/ID
- IF_ID_rs1  in  REG_ADDR_WIDTH  IF/ID.RegisterRs1
- IF_ID_rs2  in  REG_ADDR_WIDTH  IF/ID.RegisterRs2
- ID_EX_mem_read  in  1  instruction in EX is a load
- ID_EX_rd  in  REG_ADDR_WIDTH  destination register of the instruction in EX
- EX_branch_taken  in  1  branch or jump in EX redirects the PC this cycle
- EX_MEM_mem_access  in  1  load or store in the MEM stage
- dmem_ready  in  1  data memory completes the access this cycle
- imem_ready  in  1  instruction for the current PC is valid this cycle
- pc_write  out  1  PC register load enable
- IF_ID_write  out  1  IF/ID instruction write enable
- IF_flush  out  1  zero IF/ID instruction (bubble)
- ID_EX_flush  out  1  zero ID/EX control signals (bubble)
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers

Interface:
- Reset reset_n, asynchronous, active-low; clock clk.

Behaviour:
Register usage decode (combinational):
- use_rs1 = 0 for LUI 0110111, AUIPC 0010111 and JAL 1101111; 1 for every other opcode.
- use_rs2 = 1 only for R-type 0110011, STORE 0100011 and BRANCH 1100011.
- load_use = ID_EX_mem_read & (ID_EX_rd != 0) & ((use_rs1 & IF_ID_rs1 == ID_EX_rd) | (use_rs2 & IF_ID_rs2 == ID_EX_rd)).
- dmem_busy = EX_MEM_mem_access & ~dmem_ready.

States (registered) are RUN, DMEM_WAIT, IMEM_WAIT and DISCARD; the reset state is RUN. All outputs are combinational from the state and inputs. Default outputs are pc_write=1, IF_ID_write=1, IF_flush=0, ID_EX_flush=0 and pipe_freeze=0. Evaluate each cycle in the following priority order:
1. dmem_busy: pc_write=0, IF_ID_write=0, pipe_freeze=1, no flushes; next state DMEM_WAIT. A pending EX_branch_taken is held by the freeze and acted on in the first cycle after the freeze.
2. State DISCARD: the stale wrong-path fetch is still outstanding.
   - pc_write=0, IF_ID_write=0.
   - When imem_ready=1: IF_flush=1 and next state RUN. The PC already holds the target.
   - If EX_branch_taken=1 in this state, pc_write=1 and the state stays DISCARD.
3. EX_branch_taken: pc_write=1, IF_flush=1, ID_EX_flush=1. Next state is DISCARD if a fetch is in flight (imem_ready=0), else RUN.
4. load_use: pc_write=0, IF_ID_write=0, ID_EX_flush=1. Lasts exactly one cycle per hazard; the state is unchanged.
5. imem_ready=0: pc_write=0, IF_flush=1 (NOP into ID); next state IMEM_WAIT.
6. Otherwise: next state RUN.

State notes:
- DMEM_WAIT exits to RUN once dmem_busy=0. Rules 3 to 6 apply in that exit cycle.
- IMEM_WAIT uses the same rules; it exists for observability and for the performance counters.

Reset and boundary rules:
- Reset mid-operation forces RUN immediately and clears any pending discard.
- Outputs during reset are the default values with pc_write=1; the PC register itself is held in reset.
- Simultaneous branch and load_use: the branch wins, and no stall is issued.
- rd = x0 never stalls.

Optional Feature:
- Macro PIPE_HAZARD_CTRL_PERF_EN.
- When defined, adds outputs perf_stall_cnt, perf_flush_cnt and perf_loaduse_cnt, each CNT_WIDTH wide:
  - perf_stall_cnt increments on any cycle with pc_write=0.
  - perf_flush_cnt increments on each cycle where rule 3 fires.
  - perf_loaduse_cnt increments on each cycle where rule 4 fires.
  - All three reset to 0 and saturate at all-ones.
- When not defined, the ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared defines include file: opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_RTYPE, OP_STORE, OP_BRANCH), state encodings (2-bit) and REG_ADDR_WIDTH.
- One natural sub-module, pipe_hazard_reguse: the combinational use_rs1/use_rs2 decode plus the load_use compare, reusable by the forwarding unit.

Test Plan:
- Load-use: ID_EX_mem_read=1, ID_EX_rd=5, opcode 0110011, rs1=5. Expect one cycle of pc_write=0, IF_ID_write=0, ID_EX_flush=1; the next cycle (mem_read=0) returns to defaults. With rd=0, or opcode LUI with rs1 field=5, expect no stall.
- Taken branch: EX_branch_taken=1, imem_ready=1. Expect a one-cycle pulse of IF_flush=1 and ID_EX_flush=1 with pc_write=1, then state RUN.
- Imem wait: imem_ready=0 for 3 cycles. Expect pc_write=0 and IF_flush=1 for 3 cycles in state IMEM_WAIT, then defaults on the ready cycle.
- Branch during fetch: EX_branch_taken=1 with imem_ready=0, then imem_ready=0 for 2 cycles, then 1. Expect DISCARD; IF_flush=1 only on the ready cycle; pc_write=0 throughout DISCARD.
- Dmem freeze over branch: EX_MEM_mem_access=1, dmem_ready=0 for 4 cycles, with EX_branch_taken=1 held. Expect pipe_freeze=1 and no flushes for 4 cycles, then a one-cycle flush pulse.
- Reset mid-DMEM_WAIT: assert reset_n=0 on cycle 2 of the freeze. Expect RUN and defaults immediately (and, with the macro defined, all counters at 0).
